fixed_weight_word_gen: RTL and testbench
========================================

// Module: fixed_weight_word_gen
// PURPOSE
//  Stimulus-side producer for population-count checks: on request, streams every WIDTH-bit
//  word containing exactly WEIGHT ones, in ascending numeric order (Gosper sequence).
//  Sits in front of a popcount/countbits checker; each emitted word must satisfy
//  $countones(data) == weight. Output is a valid/ready stream with a last marker.
// PARAMETERS
//  WIDTH   4    word width in bits (>=2, <=32)
//  IDX_W   16   width of the emitted-word index counter
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              synchronous reset, active-high
//  start      in   1              request a new sequence; sampled only in IDLE
//  weight     in   $clog2(WIDTH+1) number of ones per word; sampled with start
//  out_valid  out  1              out_data/out_last/out_idx valid
//  out_ready  in   1              consumer accepts word when out_valid && out_ready
//  out_data   out  WIDTH          current word, exactly `weight` ones
//  out_last   out  1              current word is the final word of the sequence
//  out_idx    out  IDX_W          0-based index of current word in the sequence
//  busy       out  1              high in RUN
//  done       out  1              one-cycle pulse after the last word handshakes
//  err        out  1              one-cycle pulse: start with weight > WIDTH (rejected)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; out_valid=0, out_data=0, out_last=0, out_idx=0,
//    busy=0, done=0, err=0. Reset wins over every other event in the same cycle, incl.
//    mid-sequence: stream is abandoned, out_valid low on the following cycle, no done.
//  - FSM states: IDLE, RUN.
//    IDLE: start && weight<=WIDTH -> RUN; load out_data=(1<<weight)-1, out_idx=0,
//          out_valid=1 from the next cycle (1-cycle start-to-valid latency).
//          start && weight>WIDTH -> stay IDLE, err=1 for one cycle, nothing emitted.
//    RUN:  out_valid held 1. Handshake (valid&&ready) on non-last word: next cycle
//          out_data=next(out_data), out_idx+=1. Handshake on last word -> IDLE,
//          out_valid=0, done=1 for one cycle. start in RUN is ignored.
//  - No handshake: out_data/out_last/out_idx held stable (no change while ready low).
//  - next(x), WIDTH+1-bit internal arithmetic: c = x & -x; r = x + c;
//    next = r | (((r ^ x) >> 2) >> tz(c)), tz = trailing-zero index of c; truncate to WIDTH.
//  - out_last = (out_data == ((1<<weight)-1) << (WIDTH-weight)), registered weight.
//  - weight==0: single word 0, out_last=1. weight==WIDTH: single word all-ones, out_last=1.
//  - Sequence length = C(WIDTH,weight); out_idx of last word = C(WIDTH,weight)-1.
//    out_idx wraps modulo 2^IDX_W (no saturation); with defaults it never wraps.
//  - done and err never assert in the same cycle; busy==(state==RUN).
// STRUCTURE
//  - Package fixed_weight_pkg: state_e {IDLE,RUN}; function ctz(); function
//    first_word(w); function last_word(w); function next_word(x) shared with checker bench.
//  - One sub-module: lsb_index (combinational priority encoder, WIDTH+1 in ->
//    $clog2(WIDTH+1) out) providing tz(c); the rest is one FSM plus datapath registers.
// TESTING
//  - WIDTH=4, weight=2, ready=1 -> 0011,0101,0110,1001,1010,1100; idx 0..5; last only on 1100;
//    done pulse one cycle after 1100 handshake.
//  - weight=0 -> single word 0000 with out_last=1, idx 0; weight=4 -> single 1111, last=1.
//  - weight=5 (WIDTH=4) -> err=1 one cycle, out_valid stays 0, busy stays 0.
//  - weight=1, out_ready toggled 1-0-0-1 pattern -> data held while ready=0; 0001,0010,0100,
//    1000 each accepted once, no duplicates/skips.
//  - rst asserted after 3rd word of weight=2 -> out_valid=0 next cycle, no done; new
//    start afterwards restarts from 0011, idx 0.
//  - Every handshaked word: $countones(out_data)==weight; start during RUN has no effect.

Source files
------------

// File: rtl/fixed_weight_pkg.sv
// Shared types and reference helpers for the fixed-weight word generator.
// Word helpers work in MAX_W+1 bits so one package serves every WIDTH up to 32.
package fixed_weight_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {IDLE, RUN} state_e;
  typedef logic [MAX_W:0] word_t;

  function automatic logic [5:0] ctz(input word_t x);
    ctz = '0;
    for (int i = MAX_W; i >= 0; i--) begin
      if (x[i]) ctz = 6'(i);
    end
  endfunction

  function automatic word_t first_word(input logic [5:0] w);
    word_t one;
    one = word_t'(1);
    return (one << w) - one;
  endfunction

  function automatic word_t last_word(input logic [5:0] w, input logic [5:0] width);
    return first_word(w) << (width - w);
  endfunction

  // Gosper step: smallest larger value with the same number of ones.
  function automatic word_t next_word(input word_t x);
    word_t c;
    word_t r;
    c = x & (~x + word_t'(1));
    r = x + c;
    return r | (((r ^ x) >> 2) >> ctz(c));
  endfunction

endpackage

// File: rtl/fixed_weight_word_gen_lsb_index.sv
// Combinational priority encoder: index of the lowest set bit (0 when vec is zero).
module lsb_index #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/fixed_weight_word_gen.sv
// Streams every WIDTH-bit word with exactly `weight` ones in ascending order
// over a valid/ready interface, flagging the final word with out_last.
module fixed_weight_word_gen
  import fixed_weight_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(WIDTH+1)-1:0] weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int WW = $clog2(WIDTH + 1);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WW-1:0]    weight_reg, weight_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [WIDTH:0]   x_ext, c_ext, r_ext;
  logic [WW-1:0]    tz;
  logic [WIDTH-1:0] next_w, first_w, last_w;
  logic             is_last;

  // One extra bit so the carry out of the top bit is not lost mid-step.
  assign x_ext = {1'b0, data_reg};
  assign c_ext = x_ext & (-x_ext);
  assign r_ext = x_ext + c_ext;

  lsb_index #(.N(WIDTH + 1), .IW(WW)) u_lsb_index (
    .vec (c_ext),
    .idx (tz)
  );

  assign next_w  = WIDTH'(r_ext | (((r_ext ^ x_ext) >> 2) >> tz));
  assign first_w = WIDTH'(first_word(6'(weight)));
  assign last_w  = WIDTH'(last_word(6'(weight_reg), 6'(WIDTH)));
  assign is_last = (data_reg == last_w);

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    idx_next    = idx_reg;
    weight_next = weight_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (int'(weight) > WIDTH) begin
            err_next = 1'b1;
          end else begin
            state_next  = RUN;
            data_next   = first_w;
            idx_next    = '0;
            weight_next = weight;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (is_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            data_next = next_w;
            idx_next  = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      data_reg   <= '0;
      idx_reg    <= '0;
      weight_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      idx_reg    <= idx_next;
      weight_reg <= weight_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  assign out_valid = (state_reg == RUN);
  assign busy      = (state_reg == RUN);
  assign out_data  = data_reg;
  assign out_idx   = idx_reg;
  assign out_last  = (state_reg == RUN) && is_last;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_fixed_weight_word_gen.sv
// Scoreboard bench: the stimulus queues every expected word from a brute-force
// enumeration; a negedge monitor pops and compares on each handshake.
module tb_fixed_weight_word_gen;

  localparam int WIDTH = 4;
  localparam int IDX_W = 16;
  localparam int WW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WW-1:0]    weight = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;
  logic             busy;
  logic             done;
  logic             err;

  fixed_weight_word_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [WW-1:0]    w;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   ready_mode = 0;
  int   rphase = 0;
  bit   done_due = 0;
  bit   hold_pending = 0;
  logic [WIDTH-1:0] hold_data;
  logic [IDX_W-1:0] hold_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready shaping: 0 = always ready, 1 = random, 2 = repeating 1-0-0-1.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (rphase == 0 || rphase == 3);
        rphase = (rphase + 1) % 4;
      end
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("done", done, done_due);
      done_due = 0;
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_idx", out_idx, hold_idx);
        hold_pending = 0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got data=%b idx=%0d expected none", out_data, out_idx);
        end else begin
          e = sb_q.pop_front();
          pops++;
          $display("tx w=%0d idx=%0d data=%b last=%0b", e.w, out_idx, out_data, out_last);
          check("data", out_data, e.data);
          check("idx", out_idx, e.idx);
          check("last", out_last, e.last);
          check("popcount", $countones(out_data), e.w);
          if (e.last) done_due = 1;
        end
      end else if (out_valid) begin
        hold_pending = 1;
        hold_data = out_data;
        hold_idx = out_idx;
      end
    end else begin
      done_due = 0;
      hold_pending = 0;
    end
  end

  // Reference: all WIDTH-bit values with w ones, ascending.
  task automatic push_expected(input int w);
    int n = 0;
    int k = 0;
    exp_t e;
    for (int v = 0; v < (1 << WIDTH); v++) if ($countones(v) == w) n++;
    for (int v = 0; v < (1 << WIDTH); v++) begin
      if ($countones(v) == w) begin
        e.data = WIDTH'(v);
        e.idx = IDX_W'(k);
        e.last = (k == n - 1);
        e.w = WW'(w);
        sb_q.push_back(e);
        k++;
      end
    end
  endtask

  task automatic run_seq(input int w, input int mode, input bit noise);
    int cyc;
    ready_mode = mode;
    @(posedge clk); #1;
    start = 1'b1;
    weight = WW'(w);
    push_expected(w);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_valid", out_valid, 1);
    check("start_busy", busy, 1);
    cyc = 0;
    while ((sb_q.size() != 0 || done_due) && cyc < 2000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (noise && sb_q.size() >= 2 && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        weight = WW'($urandom_range(0, (1 << WW) - 1));
      end
      @(negedge clk);
      check("no_err_in_run", err, 0);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 2000) begin
      checks++;
      failures++;
      $display("FAIL seq_timeout: got %0d words pending expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_seq(2, 0, 0);
    run_seq(0, 0, 0);
    run_seq(WIDTH, 0, 0);
    rphase = 0;
    run_seq(1, 2, 0);

    for (int bw = WIDTH + 1; bw < (1 << WW); bw += 2) begin
      @(posedge clk); #1;
      start = 1'b1;
      weight = WW'(bw);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("err_pulse", err, 1);
      check("err_valid", out_valid, 0);
      check("err_busy", busy, 0);
      @(negedge clk);
      check("err_clear", err, 0);
      check("err_valid2", out_valid, 0);
    end

    // Abandon a weight-2 stream after its third word.
    ready_mode = 0;
    pops = 0;
    @(posedge clk); #1;
    start = 1'b1;
    weight = WW'(2);
    push_expected(2);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (pops < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached", (pops >= 3), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_idx", out_idx, 0);
    run_seq(2, 0, 0);

    for (int t = 0; t < 10; t++) begin
      run_seq($urandom_range(0, WIDTH), $urandom_range(0, 2), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
